// File: rtl/mem_access_if.sv
// ============================================================================
// Module  : mem_access_if
// Brief   : Execute-stage, data-memory and writeback bundle for mem_access.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mem_access_if;
  // execute stage
  logic        in_valid;
  logic [31:0] o;
  logic [31:0] b;
  logic [31:0] insn;
  logic [5:0]  aluop;
  logic        dmwe;
  logic        rwe;
  logic        rdst;
  logic        rwd;
  logic        dm_byte;
  logic        stall;
  // data memory
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wmask;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  // writeback stage
  logic        wb_valid;
  logic [31:0] wb_o;
  logic [31:0] wb_d;
  logic [31:0] wb_insn;
  logic [5:0]  wb_aluop;
  logic        wb_rwe;
  logic        wb_rdst;
  logic        wb_rwd;
  logic        misalign;

  modport slave (
    input  in_valid, o, b, insn, aluop, dmwe, rwe, rdst, rwd, dm_byte,
    input  dm_ack, dm_rdata,
    output stall, dm_req, dm_we, dm_addr, dm_wdata, dm_wmask,
    output wb_valid, wb_o, wb_d, wb_insn, wb_aluop, wb_rwe, wb_rdst, wb_rwd, misalign
  );

  modport master (
    output in_valid, o, b, insn, aluop, dmwe, rwe, rdst, rwd, dm_byte,
    output dm_ack, dm_rdata,
    input  stall, dm_req, dm_we, dm_addr, dm_wdata, dm_wmask,
    input  wb_valid, wb_o, wb_d, wb_insn, wb_aluop, wb_rwe, wb_rdst, wb_rwd, misalign
  );
endinterface

`default_nettype wire

// File: rtl/mem_access.sv
// ============================================================================
// Module  : mem_access
// Brief   : Memory-access pipeline stage; issues one data-memory request per
//           load/store and stalls upstream until the memory acknowledges.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_access (
  input  logic        clk,
  input  logic        rst,
  mem_access_if.slave bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic        r_dm_req;
  logic        r_dm_we;
  logic [31:0] r_dm_addr;
  logic [31:0] r_dm_wdata;
  logic [3:0]  r_dm_wmask;

  // fields of the in-flight memory op, replayed to writeback on completion
  logic [31:0] r_op_o;
  logic [31:0] r_op_insn;
  logic [5:0]  r_op_aluop;
  logic        r_op_rwe;
  logic        r_op_rdst;
  logic        r_op_rwd;
  logic        r_op_byte;

  logic        r_wb_valid;
  logic [31:0] r_wb_o;
  logic [31:0] r_wb_d;
  logic [31:0] r_wb_insn;
  logic [5:0]  r_wb_aluop;
  logic        r_wb_rwe;
  logic        r_wb_rdst;
  logic        r_wb_rwd;
  logic        r_misalign;

  logic        w_idle;
  logic        w_mem_op;
  logic        w_acc_mem;
  logic        w_acc_pass;
  logic        w_done;
  logic        w_misalign;
  logic [31:0] w_wdata;
  logic [3:0]  w_wmask;
  logic [7:0]  w_rbyte;
  logic [31:0] w_done_d;

  assign w_idle     = (r_state == S_IDLE);
  assign w_mem_op   = bus.in_valid & (bus.dmwe | bus.rwd);
  assign w_acc_mem  = w_idle & w_mem_op;
  assign w_acc_pass = w_idle & bus.in_valid & ~w_mem_op;
  assign w_done     = (r_state == S_WAIT) & r_dm_req & bus.dm_ack;

  assign w_misalign = ~bus.dm_byte & (bus.o[1:0] != 2'b00);
  assign w_wdata    = bus.dm_byte ? {4{bus.b[7:0]}} : bus.b;
  assign w_wmask    = bus.dm_byte ? (4'b1000 >> bus.o[1:0]) : 4'b1111;

  // big-endian lane select: byte offset 0 is the most significant byte
  always_comb begin
    w_rbyte = bus.dm_rdata[31:24];
    case (r_op_o[1:0])
      2'b00:   w_rbyte = bus.dm_rdata[31:24];
      2'b01:   w_rbyte = bus.dm_rdata[23:16];
      2'b10:   w_rbyte = bus.dm_rdata[15:8];
      default: w_rbyte = bus.dm_rdata[7:0];
    endcase
  end

  always_comb begin
    w_done_d = 32'h0;
    if (r_op_rwd) begin
      w_done_d = r_op_byte ? {w_rbyte, 24'h0} : bus.dm_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_mem_op) w_state_nxt = S_WAIT;
      S_WAIT:  if (w_done)   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dm_req   <= 1'b0;
      r_dm_we    <= 1'b0;
      r_dm_addr  <= 32'h0;
      r_dm_wdata <= 32'h0;
      r_dm_wmask <= 4'h0;
      r_op_o     <= 32'h0;
      r_op_insn  <= 32'h0;
      r_op_aluop <= 6'h0;
      r_op_rwe   <= 1'b0;
      r_op_rdst  <= 1'b0;
      r_op_rwd   <= 1'b0;
      r_op_byte  <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_o     <= 32'h0;
      r_wb_d     <= 32'h0;
      r_wb_insn  <= 32'h0;
      r_wb_aluop <= 6'h0;
      r_wb_rwe   <= 1'b0;
      r_wb_rdst  <= 1'b0;
      r_wb_rwd   <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      if (w_acc_pass) begin
        r_wb_valid <= 1'b1;
        r_wb_o     <= bus.o;
        r_wb_d     <= 32'h0;
        r_wb_insn  <= bus.insn;
        r_wb_aluop <= bus.aluop;
        r_wb_rwe   <= bus.rwe;
        r_wb_rdst  <= bus.rdst;
        r_wb_rwd   <= bus.rwd;
        r_misalign <= 1'b0;
      end else if (w_acc_mem) begin
        r_dm_req   <= 1'b1;
        r_dm_we    <= bus.dmwe;
        r_dm_addr  <= {bus.o[31:2], 2'b00};
        r_dm_wdata <= w_wdata;
        r_dm_wmask <= w_wmask;
        r_op_o     <= bus.o;
        r_op_insn  <= bus.insn;
        r_op_aluop <= bus.aluop;
        r_op_rwe   <= bus.rwe;
        r_op_rdst  <= bus.rdst;
        r_op_rwd   <= bus.rwd;
        r_op_byte  <= bus.dm_byte;
        r_misalign <= w_misalign;
      end else if (w_done) begin
        // misalign stays as set at issue so it lines up with this writeback
        r_dm_req   <= 1'b0;
        r_dm_we    <= 1'b0;
        r_wb_valid <= 1'b1;
        r_wb_o     <= r_op_o;
        r_wb_d     <= w_done_d;
        r_wb_insn  <= r_op_insn;
        r_wb_aluop <= r_op_aluop;
        r_wb_rwe   <= r_op_rwe;
        r_wb_rdst  <= r_op_rdst;
        r_wb_rwd   <= r_op_rwd;
      end else if (w_idle) begin
        r_misalign <= 1'b0;
      end
    end
  end

  assign bus.stall    = (r_state == S_WAIT);
  assign bus.dm_req   = r_dm_req;
  assign bus.dm_we    = r_dm_we;
  assign bus.dm_addr  = r_dm_addr;
  assign bus.dm_wdata = r_dm_wdata;
  assign bus.dm_wmask = r_dm_wmask;
  assign bus.wb_valid = r_wb_valid;
  assign bus.wb_o     = r_wb_o;
  assign bus.wb_d     = r_wb_d;
  assign bus.wb_insn  = r_wb_insn;
  assign bus.wb_aluop = r_wb_aluop;
  assign bus.wb_rwe   = r_wb_rwe;
  assign bus.wb_rdst  = r_wb_rdst;
  assign bus.wb_rwd   = r_wb_rwd;
  assign bus.misalign = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// ============================================================================
// Module  : tb_mem_access
// Brief   : Directed self-checking bench for mem_access.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_access;

  localparam logic [5:0] C_LB  = 6'b010101;
  localparam logic [5:0] C_LBU = 6'b011000;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  mem_access_if u_if ();

  mem_access dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    u_if.in_valid = 1'b0;
    u_if.o        = 32'h0;
    u_if.b        = 32'h0;
    u_if.insn     = 32'h0;
    u_if.aluop    = 6'h0;
    u_if.dmwe     = 1'b0;
    u_if.rwe      = 1'b0;
    u_if.rdst     = 1'b0;
    u_if.rwd      = 1'b0;
    u_if.dm_byte  = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    clear_in();
    u_if.dm_ack   = 1'b0;
    u_if.dm_rdata = 32'h0;
    tick();
    tick();
    check("rst_stall",    32'(u_if.stall),    32'h0);
    check("rst_dm_req",   32'(u_if.dm_req),   32'h0);
    check("rst_dm_addr",  u_if.dm_addr,       32'h0);
    check("rst_dm_wmask", 32'(u_if.dm_wmask), 32'h0);
    check("rst_wb_valid", 32'(u_if.wb_valid), 32'h0);
    check("rst_misalign", 32'(u_if.misalign), 32'h0);
    rst = 1'b0;

    // pass-through
    u_if.in_valid = 1'b1;
    u_if.o        = 32'h1234;
    u_if.rwe      = 1'b1;
    u_if.insn     = 32'hCAFE0001;
    u_if.aluop    = 6'h01;
    tick();
    check("pt_wb_valid", 32'(u_if.wb_valid), 32'h1);
    check("pt_wb_o",     u_if.wb_o,          32'h1234);
    check("pt_wb_d",     u_if.wb_d,          32'h0);
    check("pt_wb_insn",  u_if.wb_insn,       32'hCAFE0001);
    check("pt_wb_rwe",   32'(u_if.wb_rwe),   32'h1);
    check("pt_stall",    32'(u_if.stall),    32'h0);
    check("pt_dm_req",   32'(u_if.dm_req),   32'h0);

    // bubble, with a stray ack that must be ignored
    clear_in();
    u_if.dm_ack = 1'b1;
    tick();
    check("bub_wb_valid", 32'(u_if.wb_valid), 32'h0);
    check("bub_stall",    32'(u_if.stall),    32'h0);
    check("bub_dm_req",   32'(u_if.dm_req),   32'h0);
    u_if.dm_ack = 1'b0;

    // LB at 0x102, ack three cycles after request
    u_if.in_valid = 1'b1;
    u_if.o        = 32'h102;
    u_if.rwd      = 1'b1;
    u_if.dm_byte  = 1'b1;
    u_if.aluop    = C_LB;
    tick();
    clear_in();
    check("lb_dm_req",   32'(u_if.dm_req),   32'h1);
    check("lb_dm_we",    32'(u_if.dm_we),    32'h0);
    check("lb_dm_addr",  u_if.dm_addr,       32'h100);
    check("lb_stall1",   32'(u_if.stall),    32'h1);
    check("lb_wb_valid", 32'(u_if.wb_valid), 32'h0);
    tick();
    check("lb_stall2",   32'(u_if.stall),    32'h1);
    tick();
    check("lb_stall3",   32'(u_if.stall),    32'h1);
    u_if.dm_ack   = 1'b1;
    u_if.dm_rdata = 32'hAABBCCDD;
    tick();
    u_if.dm_ack = 1'b0;
    check("lb_done_valid", 32'(u_if.wb_valid), 32'h1);
    check("lb_done_d",     u_if.wb_d,          32'hCC000000);
    check("lb_done_o",     u_if.wb_o,          32'h102);
    check("lb_done_aluop", 32'(u_if.wb_aluop), 32'(C_LB));
    check("lb_done_stall", 32'(u_if.stall),    32'h0);
    check("lb_done_req",   32'(u_if.dm_req),   32'h0);

    // SB at 0x203, ack in the first WAIT cycle
    u_if.in_valid = 1'b1;
    u_if.o        = 32'h203;
    u_if.b        = 32'h5A;
    u_if.dmwe     = 1'b1;
    u_if.dm_byte  = 1'b1;
    tick();
    clear_in();
    check("sb_wdata", u_if.dm_wdata,       32'h5A5A5A5A);
    check("sb_wmask", 32'(u_if.dm_wmask),  32'h1);
    check("sb_we",    32'(u_if.dm_we),     32'h1);
    check("sb_addr",  u_if.dm_addr,        32'h200);
    u_if.dm_ack   = 1'b1;
    u_if.dm_rdata = 32'hFFFFFFFF;
    tick();
    u_if.dm_ack = 1'b0;
    check("sb_done_valid", 32'(u_if.wb_valid), 32'h1);
    check("sb_done_d",     u_if.wb_d,          32'h0);
    check("sb_done_we",    32'(u_if.dm_we),    32'h0);

    // SB at offset 0 selects the most significant lane
    u_if.in_valid = 1'b1;
    u_if.o        = 32'h400;
    u_if.b        = 32'h123456C3;
    u_if.dmwe     = 1'b1;
    u_if.dm_byte  = 1'b1;
    tick();
    clear_in();
    check("sb0_wmask", 32'(u_if.dm_wmask), 32'h8);
    check("sb0_wdata", u_if.dm_wdata,      32'hC3C3C3C3);
    u_if.dm_ack = 1'b1;
    tick();
    u_if.dm_ack = 1'b0;

    // word store
    u_if.in_valid = 1'b1;
    u_if.o        = 32'h300;
    u_if.b        = 32'hDEADBEEF;
    u_if.dmwe     = 1'b1;
    tick();
    clear_in();
    check("sw_wdata",    u_if.dm_wdata,       32'hDEADBEEF);
    check("sw_wmask",    32'(u_if.dm_wmask),  32'hF);
    check("sw_misalign", 32'(u_if.misalign),  32'h0);
    u_if.dm_ack = 1'b1;
    tick();
    u_if.dm_ack = 1'b0;

    // misaligned word load
    u_if.in_valid = 1'b1;
    u_if.o        = 32'h6;
    u_if.rwd      = 1'b1;
    tick();
    clear_in();
    check("lw_misalign", 32'(u_if.misalign), 32'h1);
    check("lw_addr",     u_if.dm_addr,       32'h4);
    u_if.dm_ack   = 1'b1;
    u_if.dm_rdata = 32'h11223344;
    tick();
    u_if.dm_ack = 1'b0;
    check("lw_done_valid",    32'(u_if.wb_valid), 32'h1);
    check("lw_done_d",        u_if.wb_d,          32'h11223344);
    check("lw_done_misalign", 32'(u_if.misalign), 32'h1);

    // reset while waiting, then a late ack
    u_if.in_valid = 1'b1;
    u_if.o        = 32'h10;
    u_if.rwd      = 1'b1;
    u_if.dm_byte  = 1'b1;
    tick();
    clear_in();
    check("rw_stall_pre", 32'(u_if.stall), 32'h1);
    rst         = 1'b1;
    u_if.dm_ack = 1'b1;
    tick();
    check("rw_dm_req",   32'(u_if.dm_req),   32'h0);
    check("rw_wb_valid", 32'(u_if.wb_valid), 32'h0);
    check("rw_stall",    32'(u_if.stall),    32'h0);
    rst = 1'b0;
    tick();
    u_if.dm_ack = 1'b0;
    check("late_wb_valid", 32'(u_if.wb_valid), 32'h0);
    check("late_stall",    32'(u_if.stall),    32'h0);
    check("late_dm_req",   32'(u_if.dm_req),   32'h0);

    // back-to-back: LBU then pass-through held during WAIT
    u_if.in_valid = 1'b1;
    u_if.o        = 32'h3;
    u_if.rwd      = 1'b1;
    u_if.dm_byte  = 1'b1;
    u_if.aluop    = C_LBU;
    tick();
    check("bb_req", 32'(u_if.dm_req), 32'h1);
    clear_in();
    u_if.in_valid = 1'b1;
    u_if.o        = 32'hABCD;
    u_if.rwe      = 1'b1;
    u_if.dm_ack   = 1'b1;
    u_if.dm_rdata = 32'h000000EE;
    tick();
    u_if.dm_ack = 1'b0;
    check("bb1_valid", 32'(u_if.wb_valid), 32'h1);
    check("bb1_o",     u_if.wb_o,          32'h3);
    check("bb1_d",     u_if.wb_d,          32'hEE000000);
    check("bb1_stall", 32'(u_if.stall),    32'h0);
    tick();
    clear_in();
    check("bb2_valid", 32'(u_if.wb_valid), 32'h1);
    check("bb2_o",     u_if.wb_o,          32'hABCD);
    check("bb2_d",     u_if.wb_d,          32'h0);
    check("bb2_req",   32'(u_if.dm_req),   32'h0);
    tick();
    check("bb3_valid", 32'(u_if.wb_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
